// File: rtl/sra_arbiter.sv
// sra_arbiter: round-robin front end that shares one SRA square-root unit among NUM_REQ
// requesters. It accepts one request at a time and latches that requester's operands. It then
// pulses sra_start and waits for sra_done. The result is returned tagged with the requester
// index. If the SRA stays silent for TIMEOUT_CYC cycles, a watchdog pulses sra_clr low for
// CLR_CYC cycles and returns an error response.
//
// Ports:
//   clk        rising-edge clock
//   CLR        synchronous active-low reset
//   req        per-requester request level
//   req_in1    packed In1 operands, requester i at [8i+7:8i]
//   req_in2    packed In2 operands, same packing
//   gnt        one-hot accept pulse (operands captured)
//   rsp_valid  one-cycle response strobe
//   rsp_id     index of the requester being answered
//   rsp_data   SRA result, 8'h00 on timeout
//   rsp_err    1 = timeout abort, qualifies rsp_valid
//   busy       high in every state except idle
//   sra_start  SRA Start pulse
//   sra_in1    SRA In1, held from issue until back in idle
//   sra_in2    SRA In2, same hold rule
//   sra_clr    SRA CLR, active-low; low during reset and recovery
//   sra_out    SRA Out
//   sra_done   SRA Done
module sra_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned ID_W        = 2,
   parameter int unsigned TIMEOUT_CYC = 64,
   parameter int unsigned CLR_CYC     = 2
) (
   input  logic                 clk,
   input  logic                 CLR,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_in1,
   input  logic [8*NUM_REQ-1:0] req_in2,
   output logic [NUM_REQ-1:0]   gnt,
   output logic                 rsp_valid,
   output logic [ID_W-1:0]      rsp_id,
   output logic [7:0]           rsp_data,
   output logic                 rsp_err,
   output logic                 busy,
   output logic                 sra_start,
   output logic [7:0]           sra_in1,
   output logic [7:0]           sra_in2,
   output logic                 sra_clr,
   input  logic [7:0]           sra_out,
   input  logic                 sra_done
);

   localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYC);
   localparam int unsigned CNT_W  = $clog2(CLR_CYC + 1);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StRecover} state_e;

   state_e            state;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   id_q;
   logic [WDOG_W-1:0] wdog;
   logic [CNT_W-1:0]  clr_cnt;
   logic [ID_W-1:0]   win_idx;
   logic              win_found;

   // Round-robin search: first set request strictly after rr_ptr, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 1; i <= int'(NUM_REQ); i++) begin
         int idx;
         idx = int'(rr_ptr) + i;
         if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_idx   = ID_W'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!CLR) begin
         state     <= StIdle;
         rr_ptr    <= ID_W'(NUM_REQ - 1);
         id_q      <= '0;
         wdog      <= '0;
         clr_cnt   <= '0;
         gnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
         sra_start <= 1'b0;
         sra_in1   <= '0;
         sra_in2   <= '0;
         sra_clr   <= 1'b0;
      end else begin
         // Pulse outputs default low; sra_clr is only pulled low in recovery.
         sra_clr   <= 1'b1;
         gnt       <= '0;
         sra_start <= 1'b0;
         unique case (state)
            StIdle: begin
               if (win_found) begin
                  sra_in1   <= req_in1[win_idx*8 +: 8];
                  sra_in2   <= req_in2[win_idx*8 +: 8];
                  id_q      <= win_idx;
                  rr_ptr    <= win_idx;
                  gnt       <= NUM_REQ'(1) << win_idx;
                  sra_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= StIssue;
               end
            end
            StIssue: begin
               wdog  <= '0;
               state <= StWait;
            end
            StWait: begin
               wdog <= wdog + 1'b1;
               // wdog==0 marks the first wait cycle, where a leftover Done is ignored.
               if (wdog != '0 && sra_done) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= sra_out;
                  rsp_id    <= id_q;
                  state     <= StResp;
               end else if (wdog == WDOG_W'(TIMEOUT_CYC - 1)) begin
                  sra_clr <= 1'b0;
                  clr_cnt <= '0;
                  state   <= StRecover;
               end
            end
            StRecover: begin
               if (clr_cnt == CNT_W'(CLR_CYC - 1)) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= '0;
                  rsp_id    <= id_q;
                  state     <= StResp;
               end else begin
                  sra_clr <= 1'b0;
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            StResp: begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_data  <= '0;
               rsp_id    <= '0;
               busy      <= 1'b0;
               state     <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sra_arbiter.sv
module tb_sra_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int TIMEOUT = 64;

   logic                 clk = 1'b0;
   logic                 CLR;
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_in1;
   logic [8*NUM_REQ-1:0] req_in2;
   logic [NUM_REQ-1:0]   gnt;
   logic                 rsp_valid;
   logic [ID_W-1:0]      rsp_id;
   logic [7:0]           rsp_data;
   logic                 rsp_err;
   logic                 busy;
   logic                 sra_start;
   logic [7:0]           sra_in1;
   logic [7:0]           sra_in2;
   logic                 sra_clr;
   logic [7:0]           sra_out;
   logic                 sra_done;

   int n_total = 0;
   int n_bad   = 0;

   // SRA model controls
   int   lat   = 10;
   bit   never = 1'b0;
   bit   stale = 1'b0;
   logic run;
   int   cnt;
   logic done_m;
   logic [7:0] out_m;

   always #5 clk = ~clk;

   sra_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .ID_W       (ID_W),
      .TIMEOUT_CYC(TIMEOUT),
      .CLR_CYC    (2)
   ) dut (
      .clk      (clk),
      .CLR      (CLR),
      .req      (req),
      .req_in1  (req_in1),
      .req_in2  (req_in2),
      .gnt      (gnt),
      .rsp_valid(rsp_valid),
      .rsp_id   (rsp_id),
      .rsp_data (rsp_data),
      .rsp_err  (rsp_err),
      .busy     (busy),
      .sra_start(sra_start),
      .sra_in1  (sra_in1),
      .sra_in2  (sra_in2),
      .sra_clr  (sra_clr),
      .sra_out  (sra_out),
      .sra_done (sra_done)
   );

   function automatic logic [7:0] isqrt(input logic [7:0] v);
      logic [7:0] r;
      r = 8'd0;
      for (int k = 0; k < 16; k++) if (k * k <= int'(v)) r = 8'(k);
      return r;
   endfunction

   // Square-root unit model: Done pulses lat cycles after Start, result is isqrt(In1).
   always @(posedge clk) begin
      done_m <= 1'b0;
      if (!CLR || !sra_clr) begin
         run <= 1'b0;
         cnt <= 0;
      end else if (sra_start) begin
         run <= 1'b1;
         cnt <= 1;
      end else if (run && !never) begin
         if (cnt >= lat) begin
            done_m <= 1'b1;
            out_m  <= isqrt(sra_in1);
            run    <= 1'b0;
         end else begin
            cnt <= cnt + 1;
         end
      end
   end

   // A stale Done shows up with a poison value on Out.
   assign sra_done = done_m | stale;
   assign sra_out  = stale ? 8'hEE : out_m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
      req_in1[i*8 +: 8] = a;
      req_in2[i*8 +: 8] = b;
   endtask

   task automatic pulse_reset(input int cycles);
      @(negedge clk);
      CLR = 1'b0;
      repeat (cycles) @(negedge clk);
      CLR = 1'b1;
   endtask

   // Waits for a grant, then for the response; checks grant, single Start, and response fields.
   task automatic do_op(input int exp_id, input logic [7:0] exp_data, input bit drop_req,
                        input bit drop_stale);
      bit seen;
      int starts;
      seen = 1'b0;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         if (gnt != '0) seen = 1'b1;
      end
      check("gnt_seen", 32'(seen), 32'd1);
      if (!seen) return;
      check("gnt_onehot", 32'(gnt), 32'd1 << exp_id);
      starts = sra_start ? 1 : 0;
      if (drop_req) req[exp_id] = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 300 && !seen; n++) begin
         @(negedge clk);
         if (drop_stale && n == 1) stale = 1'b0;
         if (sra_start) starts++;
         if (rsp_valid) seen = 1'b1;
      end
      check("rsp_seen", 32'(seen), 32'd1);
      check("start_count", 32'(starts), 32'd1);
      check("rsp_id", 32'(rsp_id), 32'(exp_id));
      check("rsp_data", 32'(rsp_data), 32'(exp_data));
      check("rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      check("rsp_single", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      CLR     = 1'b0;
      req     = 4'hF;
      req_in1 = '0;
      req_in2 = '0;

      // 1. reset held with all requests up
      repeat (3) begin
         @(negedge clk);
         check("rst_gnt", 32'(gnt), 32'd0);
         check("rst_rsp", 32'(rsp_valid), 32'd0);
         check("rst_clr", 32'(sra_clr), 32'd0);
      end
      CLR = 1'b1;
      req = 4'h0;
      @(negedge clk);
      check("rel_busy", 32'(busy), 32'd0);
      check("rel_clr", 32'(sra_clr), 32'd1);

      // 2. single request from requester 2
      lat = 10;
      set_op(2, 8'd144, 8'd7);
      req = 4'b0100;
      do_op(2, 8'd12, 1'b1, 1'b0);

      // 3. round-robin with all requests held, starting from a fresh pointer
      pulse_reset(2);
      lat = 3;
      set_op(0, 8'd16, 8'd1);
      set_op(1, 8'd81, 8'd2);
      set_op(2, 8'd144, 8'd3);
      set_op(3, 8'd225, 8'd4);
      req = 4'hF;
      for (int k = 0; k < 8; k++) begin
         case (k % 4)
            0: do_op(0, 8'd4, 1'b0, 1'b0);
            1: do_op(1, 8'd9, 1'b0, 1'b0);
            2: do_op(2, 8'd12, 1'b0, 1'b0);
            default: do_op(3, 8'd15, 1'b0, 1'b0);
         endcase
      end
      req = 4'h0;

      // 4. timeout: the SRA never answers
      never = 1'b1;
      set_op(1, 8'd100, 8'd5);
      @(negedge clk);
      req = 4'b0010;
      begin
         bit seen;
         int waited;
         int early_rsp;
         seen = 1'b0;
         for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (gnt != '0) seen = 1'b1;
         end
         check("to_gnt", 32'(gnt), 32'b0010);
         req = 4'h0;
         seen = 1'b0;
         waited = 0;
         early_rsp = 0;
         for (int n = 1; n <= 200 && !seen; n++) begin
            @(negedge clk);
            waited = n;
            if (rsp_valid) early_rsp++;
            if (!sra_clr) seen = 1'b1;
         end
         check("to_clr_delay", 32'(waited), 32'(TIMEOUT + 1));
         check("to_no_early_rsp", 32'(early_rsp), 32'd0);
         @(negedge clk);
         check("to_clr_2nd", 32'(sra_clr), 32'd0);
         check("to_rsp_hold", 32'(rsp_valid), 32'd0);
         @(negedge clk);
         check("to_clr_end", 32'(sra_clr), 32'd1);
         check("to_rsp_valid", 32'(rsp_valid), 32'd1);
         check("to_rsp_err", 32'(rsp_err), 32'd1);
         check("to_rsp_data", 32'(rsp_data), 32'd0);
         check("to_rsp_id", 32'(rsp_id), 32'd1);
         check("to_busy", 32'(busy), 32'd1);
      end
      never = 1'b0;
      lat = 4;
      set_op(3, 8'd225, 8'd6);
      req = 4'b1000;
      do_op(3, 8'd15, 1'b1, 1'b0);

      // 5. stale Done held high through issue and the first wait cycle
      lat = 5;
      stale = 1'b1;
      set_op(0, 8'd49, 8'd8);
      repeat (2) @(negedge clk);
      req = 4'b0001;
      do_op(0, 8'd7, 1'b1, 1'b1);

      // 6. reset in the middle of a wait
      lat = 20;
      set_op(2, 8'd64, 8'd9);
      req = 4'b0100;
      begin
         bit seen;
         int rsp_cnt;
         seen = 1'b0;
         for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (gnt != '0) seen = 1'b1;
         end
         check("mid_gnt", 32'(gnt), 32'b0100);
         req = 4'h0;
         repeat (3) @(negedge clk);
         CLR = 1'b0;
         rsp_cnt = 0;
         repeat (2) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
         end
         CLR = 1'b1;
         @(negedge clk);
         check("mid_busy", 32'(busy), 32'd0);
         repeat (30) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
         end
         check("mid_no_rsp", 32'(rsp_cnt), 32'd0);
      end
      set_op(0, 8'd36, 8'd1);
      set_op(3, 8'd9, 8'd2);
      lat = 2;
      req = 4'b1001;
      do_op(0, 8'd6, 1'b1, 1'b0);
      do_op(3, 8'd3, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
